// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared FSM state encodings and default gesture thresholds
package button_event_decoder_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_LONG   = 3'd4;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_LONG_CYCLES   = 100;
  localparam int DEF_GAP_CYCLES    = 30;
  localparam int DEF_REPEAT_CYCLES = 50;
endpackage

// File: rtl/button_edge_detect.sv
// button_edge_detect: registers a level and flags its rising/falling edges
// Ports: clk, rst (async, active-low), d (level in), q (registered d), rise/fall (combinational edges)
module button_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: decodes a clean button level into press/release/click/dclick/long/repeat strobes
// Ports: clk, rst (async, active-low), btn_sync (1 = pressed); outputs press_pulse, release_pulse,
//   click_pulse, dclick_pulse, long_pulse, repeat_pulse (1-cycle strobes) and held (registered level).
// Build option: define BTN_REPEAT_EN to enable auto-repeat strobes while long-held.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse,
  output logic held,
  output logic repeat_pulse
);
  logic rise, fall, long_n, click_n, dclick_n;
  logic [2:0] st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  button_edge_detect u_edge (
    .clk (clk),
    .rst (rst),
    .d   (btn_sync),
    .q   (held),
    .rise(rise),
    .fall(fall)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  // Edges are tested before thresholds, so an edge on the threshold cycle wins.
  always_comb begin
    st_n = st;
    long_n = 1'b0;
    click_n = 1'b0;
    dclick_n = 1'b0;
    case (st)
      ST_IDLE:   st_n = rise ? ST_PRESS1 : ST_IDLE;
      ST_PRESS1: begin
        long_n = ~fall & (cnt_inc == CNT_W'(LONG_CYCLES));
        st_n = fall ? ST_GAP : long_n ? ST_LONG : ST_PRESS1;
      end
      ST_GAP: begin
        click_n = ~rise & (cnt_inc == CNT_W'(GAP_CYCLES));
        st_n = rise ? ST_PRESS2 : click_n ? ST_IDLE : ST_GAP;
      end
      ST_PRESS2: begin
        dclick_n = fall;
        st_n = fall ? ST_IDLE : ST_PRESS2;
      end
      ST_LONG:   st_n = fall ? ST_IDLE : ST_LONG;
      default:   st_n = ST_IDLE;
    endcase
  end
  // The edge that enters PRESS1/GAP is itself the first counted sample.
  assign cnt_n = (st_n != st) ? ((st_n == ST_PRESS1 || st_n == ST_GAP) ? CNT_W'(1) : '0)
               : (st == ST_IDLE) ? '0 : cnt_inc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse <= 1'b0;
      dclick_pulse <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      press_pulse <= rise;
      release_pulse <= fall;
      click_pulse <= click_n;
      dclick_pulse <= dclick_n;
      long_pulse <= long_n;
    end
`ifdef BTN_REPEAT_EN
  logic [CNT_W-1:0] rcnt;
  logic rep_hit, rep_run;
  // rcnt is zero on entry to LONG, so the first repeat lands REPEAT_CYCLES after long_pulse.
  assign rep_run = (st == ST_LONG) & ~fall;
  assign rep_hit = rep_run & (rcnt == CNT_W'(REPEAT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rcnt <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rcnt <= (rep_run & ~rep_hit) ? rcnt + 1'b1 : '0;
      repeat_pulse <= rep_hit;
    end
`else
  logic unused_repeat;
  assign unused_repeat = |REPEAT_CYCLES;
  assign repeat_pulse = 1'b0;
`endif
endmodule
